lite_nasti_read_bridge: RTL and testbench

Next-generation NASTI-lite to NASTI read converter. Accepts single-word lite reads and issues NASTI reads, for either width direction: NASTI narrower than lite (multi-beat burst assembly) or NASTI wider or equal (lane extraction). Tracks up to MAX_TRANSACTION distinct-ID reads. Returns responses through a registered response FIFO, so lite_r_ready back-pressure never drops NASTI data. Sits between lite peripherals/masters and the NASTI crossbar.

---
 rtl/lite_nasti_read_bridge.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lite_nasti_read_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lite_nasti_read_bridge.sv
// NASTI-lite to NASTI read bridge: per-ID slots assemble or extract the lite word and queue it in a response FIFO.
// Optional per-slot watchdog enabled by defining LITE_NASTI_READ_BRIDGE_TIMEOUT_EN.
module lite_nasti_read_bridge #(
    parameter int MAX_TRANSACTION  = 4,
    parameter int ID_WIDTH         = 2,
    parameter int ADDR_WIDTH       = 16,
    parameter int NASTI_DATA_WIDTH = 16,
    parameter int LITE_DATA_WIDTH  = 32,
    parameter int RESP_FIFO_DEPTH  = 2,
    parameter int TIMEOUT          = 256
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ID_WIDTH-1:0]         lite_ar_id,
    input  logic [ADDR_WIDTH-1:0]       lite_ar_addr,
    input  logic [2:0]                  lite_ar_prot,
    input  logic                        lite_ar_valid,
    output logic                        lite_ar_ready,
    output logic [ID_WIDTH-1:0]         lite_r_id,
    output logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
    output logic [1:0]                  lite_r_resp,
    output logic                        lite_r_valid,
    input  logic                        lite_r_ready,
    output logic [ID_WIDTH-1:0]         nasti_ar_id,
    output logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
    output logic [7:0]                  nasti_ar_len,
    output logic [2:0]                  nasti_ar_size,
    output logic [1:0]                  nasti_ar_burst,
    output logic [2:0]                  nasti_ar_prot,
    output logic                        nasti_ar_valid,
    input  logic                        nasti_ar_ready,
    input  logic [ID_WIDTH-1:0]         nasti_r_id,
    input  logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
    input  logic [1:0]                  nasti_r_resp,
    input  logic                        nasti_r_last,
    input  logic                        nasti_r_valid,
    output logic                        nasti_r_ready
);

    localparam int NW       = NASTI_DATA_WIDTH;
    localparam int LW       = LITE_DATA_WIDTH;
    localparam int R        = (NW < LW) ? LW / NW : 1;
    localparam int WW       = (NW < LW) ? NW : LW;
    localparam int LANES    = (NW > LW) ? NW / LW : 1;
    localparam int OFF_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W    = (R > 1) ? $clog2(R) : 1;
    localparam int SLOT_W   = (MAX_TRANSACTION > 1) ? $clog2(MAX_TRANSACTION) : 1;
    localparam int PTR_W    = $clog2(RESP_FIFO_DEPTH);
    localparam int LITE_LSB = $clog2(LW / 8);

    if (LW != 32 && LW != 64) begin : g_bad_lite
        $fatal(1, "LITE_DATA_WIDTH must be 32 or 64");
    end
    if (NW < 8 || NW > 512 || (NW & (NW - 1)) != 0) begin : g_bad_nasti
        $fatal(1, "NASTI_DATA_WIDTH must be a power of 2 in 8..512");
    end
    if (RESP_FIFO_DEPTH < 2 || (RESP_FIFO_DEPTH & (RESP_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "RESP_FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (MAX_TRANSACTION < 1 || TIMEOUT < 1) begin : g_bad_slots
        $fatal(1, "MAX_TRANSACTION and TIMEOUT must be at least 1");
    end

    logic [MAX_TRANSACTION-1:0] slot_valid;
    logic [ID_WIDTH-1:0]        slot_id   [MAX_TRANSACTION];
    logic [OFF_W-1:0]           slot_off  [MAX_TRANSACTION];
    logic [CNT_W-1:0]           slot_cnt  [MAX_TRANSACTION];
    logic [1:0]                 slot_resp [MAX_TRANSACTION];
    logic [LW-1:0]              slot_data [MAX_TRANSACTION];

    logic              free, conflict, ar_fire;
    logic [SLOT_W-1:0] alloc_idx;
    logic [OFF_W-1:0]  ar_off;

    logic              hit, cnt_end, is_final, full_eff, pop, beat_fire, beat_done;
    logic [SLOT_W-1:0] hit_idx;
    logic [CNT_W-1:0]  cur_cnt;
    logic [WW-1:0]     beat_word;
    logic [1:0]        merged, final_resp;
    logic [LW-1:0]     asm_data;

    logic              tmo_push;
    logic [SLOT_W-1:0] tmo_idx;

    logic              push;
    logic [ID_WIDTH-1:0] push_id;
    logic [LW-1:0]     push_data;
    logic [1:0]        push_resp;

    logic [ID_WIDTH-1:0] fifo_id   [RESP_FIFO_DEPTH];
    logic [LW-1:0]       fifo_data [RESP_FIFO_DEPTH];
    logic [1:0]          fifo_resp [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [PTR_W:0]      fifo_cnt;
    logic                fifo_full;

    always_comb begin
        free      = 1'b0;
        conflict  = 1'b0;
        alloc_idx = '0;
        for (int i = MAX_TRANSACTION - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free      = 1'b1;
                alloc_idx = SLOT_W'(i);
            end
            if (slot_valid[i] && slot_id[i] == lite_ar_id) conflict = 1'b1;
        end
        ar_off = (LANES > 1) ? lite_ar_addr[LITE_LSB +: OFF_W] : '0;
    end

    assign nasti_ar_valid = lite_ar_valid && free && !conflict;
    assign lite_ar_ready  = nasti_ar_ready && free && !conflict;
    assign ar_fire        = lite_ar_valid && lite_ar_ready;
    assign nasti_ar_id    = lite_ar_id;
    assign nasti_ar_addr  = lite_ar_addr & ~ADDR_WIDTH'(NW / 8 - 1);
    assign nasti_ar_len   = 8'(R - 1);
    assign nasti_ar_size  = 3'($clog2(WW / 8));
    assign nasti_ar_burst = 2'b01;
    assign nasti_ar_prot  = lite_ar_prot;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_TRANSACTION; i++) begin
            if (slot_valid[i] && slot_id[i] == nasti_r_id) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
        end
        cur_cnt  = slot_cnt[hit_idx];
        cnt_end  = (cur_cnt == CNT_W'(R - 1));
        is_final = cnt_end || nasti_r_last;
        // wide NASTI: pick the lane the lite address pointed at
        beat_word = '0;
        for (int l = 0; l < LANES; l++) begin
            if (slot_off[hit_idx] == OFF_W'(l)) beat_word = nasti_r_data[l*WW +: WW];
        end
        merged     = (nasti_r_resp > slot_resp[hit_idx]) ? nasti_r_resp : slot_resp[hit_idx];
        final_resp = (cnt_end != nasti_r_last) ? 2'b10 : merged;
        asm_data   = '0;
        for (int w = 0; w < R; w++) begin
            if (CNT_W'(w) < cur_cnt)       asm_data[w*WW +: WW] = slot_data[hit_idx][w*WW +: WW];
            else if (CNT_W'(w) == cur_cnt) asm_data[w*WW +: WW] = beat_word;
        end
    end

    assign pop           = lite_r_valid && lite_r_ready;
    assign fifo_full     = (fifo_cnt == (PTR_W + 1)'(RESP_FIFO_DEPTH));
    // a pop in the same cycle frees the entry the final beat needs
    assign full_eff      = fifo_full && !pop;
    assign nasti_r_ready = !hit || !(is_final && full_eff);
    assign beat_fire     = nasti_r_valid && nasti_r_ready && hit;
    assign beat_done     = beat_fire && is_final;

`ifdef LITE_NASTI_READ_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt [MAX_TRANSACTION];
    logic             tmo_hit;

    always_comb begin
        tmo_hit = 1'b0;
        tmo_idx = '0;
        for (int i = MAX_TRANSACTION - 1; i >= 0; i--) begin
            if (slot_valid[i] && tmo_cnt[i] == TMO_W'(TIMEOUT) &&
                !(beat_fire && hit_idx == SLOT_W'(i))) begin
                tmo_hit = 1'b1;
                tmo_idx = SLOT_W'(i);
            end
        end
        // completions own the single push port; a timeout waits a cycle
        tmo_push = tmo_hit && !beat_done && !full_eff;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_TRANSACTION; i++) tmo_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_TRANSACTION; i++) begin
                if (ar_fire && alloc_idx == SLOT_W'(i))
                    tmo_cnt[i] <= '0;
                else if (beat_fire && hit_idx == SLOT_W'(i))
                    tmo_cnt[i] <= '0;
                else if (slot_valid[i] && tmo_cnt[i] != TMO_W'(TIMEOUT))
                    tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign tmo_push = 1'b0;
    assign tmo_idx  = '0;
`endif

    always_comb begin
        push      = beat_done || tmo_push;
        push_id   = beat_done ? nasti_r_id : slot_id[tmo_idx];
        push_data = beat_done ? asm_data : '0;
        push_resp = beat_done ? final_resp : 2'b10;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_valid <= '0;
            for (int i = 0; i < MAX_TRANSACTION; i++) begin
                slot_id[i]   <= '0;
                slot_off[i]  <= '0;
                slot_cnt[i]  <= '0;
                slot_resp[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            if (beat_fire && !is_final) begin
                slot_cnt[hit_idx]  <= cur_cnt + 1'b1;
                slot_resp[hit_idx] <= merged;
                for (int w = 0; w < R; w++) begin
                    if (CNT_W'(w) == cur_cnt) slot_data[hit_idx][w*WW +: WW] <= beat_word;
                end
            end
            if (beat_done) slot_valid[hit_idx] <= 1'b0;
            if (tmo_push)  slot_valid[tmo_idx] <= 1'b0;
            if (ar_fire) begin
                slot_valid[alloc_idx] <= 1'b1;
                slot_id[alloc_idx]    <= lite_ar_id;
                slot_off[alloc_idx]   <= ar_off;
                slot_cnt[alloc_idx]   <= '0;
                slot_resp[alloc_idx]  <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_id[i]   <= '0;
                fifo_data[i] <= '0;
                fifo_resp[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_id[wr_ptr]   <= push_id;
                fifo_data[wr_ptr] <= push_data;
                fifo_resp[wr_ptr] <= push_resp;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign lite_r_valid = (fifo_cnt != '0);
    assign lite_r_id    = fifo_id[rd_ptr];
    assign lite_r_data  = fifo_data[rd_ptr];
    assign lite_r_resp  = fifo_resp[rd_ptr];

endmodule

// File: tb/tb_lite_nasti_read_bridge.sv
// Directed bench for lite_nasti_read_bridge: 16-bit NASTI burst assembly and 64-bit NASTI lane extraction.
`timescale 1ns/1ps
module tb_lite_nasti_read_bridge;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // narrow instance: NASTI 16, lite 32
    logic [1:0]  ar_id;   logic [15:0] ar_addr; logic [2:0] ar_prot; logic ar_valid, ar_ready;
    logic [1:0]  r_id;    logic [31:0] r_data;  logic [1:0] r_resp;  logic r_valid, r_ready;
    logic [1:0]  n_ar_id; logic [15:0] n_ar_addr; logic [7:0] n_ar_len; logic [2:0] n_ar_size;
    logic [1:0]  n_ar_burst; logic [2:0] n_ar_prot; logic n_ar_valid, n_ar_ready;
    logic [1:0]  n_r_id;  logic [15:0] n_r_data; logic [1:0] n_r_resp;
    logic        n_r_last, n_r_valid, n_r_ready;

    // wide instance: NASTI 64, lite 32
    logic [1:0]  w_ar_id;   logic [15:0] w_ar_addr; logic [2:0] w_ar_prot; logic w_ar_valid, w_ar_ready;
    logic [1:0]  w_r_id;    logic [31:0] w_r_data;  logic [1:0] w_r_resp;  logic w_r_valid, w_r_ready;
    logic [1:0]  w_n_ar_id; logic [15:0] w_n_ar_addr; logic [7:0] w_n_ar_len; logic [2:0] w_n_ar_size;
    logic [1:0]  w_n_ar_burst; logic [2:0] w_n_ar_prot; logic w_n_ar_valid, w_n_ar_ready;
    logic [1:0]  w_n_r_id;  logic [63:0] w_n_r_data; logic [1:0] w_n_r_resp;
    logic        w_n_r_last, w_n_r_valid, w_n_r_ready;

    lite_nasti_read_bridge #(
        .MAX_TRANSACTION(4), .ID_WIDTH(2), .ADDR_WIDTH(16), .NASTI_DATA_WIDTH(16),
        .LITE_DATA_WIDTH(32), .RESP_FIFO_DEPTH(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rstn(rstn),
        .lite_ar_id(ar_id), .lite_ar_addr(ar_addr), .lite_ar_prot(ar_prot),
        .lite_ar_valid(ar_valid), .lite_ar_ready(ar_ready),
        .lite_r_id(r_id), .lite_r_data(r_data), .lite_r_resp(r_resp),
        .lite_r_valid(r_valid), .lite_r_ready(r_ready),
        .nasti_ar_id(n_ar_id), .nasti_ar_addr(n_ar_addr), .nasti_ar_len(n_ar_len),
        .nasti_ar_size(n_ar_size), .nasti_ar_burst(n_ar_burst), .nasti_ar_prot(n_ar_prot),
        .nasti_ar_valid(n_ar_valid), .nasti_ar_ready(n_ar_ready),
        .nasti_r_id(n_r_id), .nasti_r_data(n_r_data), .nasti_r_resp(n_r_resp),
        .nasti_r_last(n_r_last), .nasti_r_valid(n_r_valid), .nasti_r_ready(n_r_ready)
    );

    lite_nasti_read_bridge #(
        .MAX_TRANSACTION(4), .ID_WIDTH(2), .ADDR_WIDTH(16), .NASTI_DATA_WIDTH(64),
        .LITE_DATA_WIDTH(32), .RESP_FIFO_DEPTH(2), .TIMEOUT(256)
    ) dut_w (
        .clk(clk), .rstn(rstn),
        .lite_ar_id(w_ar_id), .lite_ar_addr(w_ar_addr), .lite_ar_prot(w_ar_prot),
        .lite_ar_valid(w_ar_valid), .lite_ar_ready(w_ar_ready),
        .lite_r_id(w_r_id), .lite_r_data(w_r_data), .lite_r_resp(w_r_resp),
        .lite_r_valid(w_r_valid), .lite_r_ready(w_r_ready),
        .nasti_ar_id(w_n_ar_id), .nasti_ar_addr(w_n_ar_addr), .nasti_ar_len(w_n_ar_len),
        .nasti_ar_size(w_n_ar_size), .nasti_ar_burst(w_n_ar_burst), .nasti_ar_prot(w_n_ar_prot),
        .nasti_ar_valid(w_n_ar_valid), .nasti_ar_ready(w_n_ar_ready),
        .nasti_r_id(w_n_r_id), .nasti_r_data(w_n_r_data), .nasti_r_resp(w_n_r_resp),
        .nasti_r_last(w_n_r_last), .nasti_r_valid(w_n_r_valid), .nasti_r_ready(w_n_r_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one lite request, handshake on the next edge
    task automatic lite_req(input logic [1:0] id, input logic [15:0] addr);
        ar_id = id; ar_addr = addr; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic beat(input logic [1:0] id, input logic [15:0] data, input logic [1:0] resp,
                        input logic last);
        n_r_id = id; n_r_data = data; n_r_resp = resp; n_r_last = last; n_r_valid = 1'b1;
        tick();
        n_r_valid = 1'b0; n_r_last = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ar_id = '0; ar_addr = '0; ar_prot = '0; ar_valid = 1'b0; r_ready = 1'b1; n_ar_ready = 1'b1;
        n_r_id = '0; n_r_data = '0; n_r_resp = '0; n_r_last = 1'b0; n_r_valid = 1'b0;
        w_ar_id = '0; w_ar_addr = '0; w_ar_prot = '0; w_ar_valid = 1'b0; w_r_ready = 1'b1; w_n_ar_ready = 1'b1;
        w_n_r_id = '0; w_n_r_data = '0; w_n_r_resp = '0; w_n_r_last = 1'b0; w_n_r_valid = 1'b0;
        repeat (3) tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b want 0", r_valid); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_r_data got %h want 0", r_data); end
        checks++; if ({r_id, r_resp} !== 4'h0) begin errors++; $display("FAIL reset_r_id_resp got %h want 0", {r_id, r_resp}); end
        checks++; if (n_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_n_ar_valid got %b want 0", n_ar_valid); end
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL reset_ar_ready got %b want 1", ar_ready); end
        checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL reset_w_r_valid got %b want 0", w_r_valid); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_narrow_burst();
        ar_id = 2'd1; ar_addr = 16'h0010; ar_prot = 3'b010; ar_valid = 1'b1;
        #1;
        checks++; if (n_ar_valid !== 1'b1) begin errors++; $display("FAIL nb_ar_valid got %b want 1", n_ar_valid); end
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL nb_ar_ready got %b want 1", ar_ready); end
        checks++; if (n_ar_addr !== 16'h0010) begin errors++; $display("FAIL nb_ar_addr got %h want 0010", n_ar_addr); end
        checks++; if (n_ar_len !== 8'd1) begin errors++; $display("FAIL nb_ar_len got %0d want 1", n_ar_len); end
        checks++; if (n_ar_size !== 3'd1) begin errors++; $display("FAIL nb_ar_size got %0d want 1", n_ar_size); end
        checks++; if ({n_ar_burst, n_ar_prot, n_ar_id} !== {2'b01, 3'b010, 2'd1}) begin
            errors++; $display("FAIL nb_ar_fields got %b want 0101001", {n_ar_burst, n_ar_prot, n_ar_id}); end
        tick();
        ar_valid = 1'b0;
        n_r_id = 2'd1; n_r_data = 16'hBEEF; n_r_resp = 2'b00; n_r_last = 1'b0; n_r_valid = 1'b1;
        #1;
        checks++; if (n_r_ready !== 1'b1) begin errors++; $display("FAIL nb_r_ready got %b want 1", n_r_ready); end
        tick();
        n_r_data = 16'hDEAD; n_r_last = 1'b1;
        #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL nb_early_valid got %b want 0", r_valid); end
        tick();
        n_r_valid = 1'b0; n_r_last = 1'b0;
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL nb_latency got %b want 1", r_valid); end
        checks++; if (r_data !== 32'hDEADBEEF) begin errors++; $display("FAIL nb_data got %h want DEADBEEF", r_data); end
        checks++; if ({r_id, r_resp} !== {2'd1, 2'b00}) begin errors++; $display("FAIL nb_id_resp got %b want 0100", {r_id, r_resp}); end
        tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL nb_pop got %b want 0", r_valid); end
    endtask

    task automatic test_wide_lane();
        w_ar_id = 2'd2; w_ar_addr = 16'h0004; w_ar_valid = 1'b1;
        #1;
        checks++; if (w_n_ar_addr !== 16'h0000) begin errors++; $display("FAIL wd_ar_addr got %h want 0000", w_n_ar_addr); end
        checks++; if (w_n_ar_len !== 8'd0) begin errors++; $display("FAIL wd_ar_len got %0d want 0", w_n_ar_len); end
        checks++; if (w_n_ar_size !== 3'd2) begin errors++; $display("FAIL wd_ar_size got %0d want 2", w_n_ar_size); end
        tick();
        w_ar_valid = 1'b0;
        w_n_r_id = 2'd2; w_n_r_data = 64'h11223344_55667788; w_n_r_resp = 2'b00; w_n_r_last = 1'b1; w_n_r_valid = 1'b1;
        tick();
        w_n_r_valid = 1'b0;
        checks++; if (w_r_valid !== 1'b1) begin errors++; $display("FAIL wd_valid got %b want 1", w_r_valid); end
        checks++; if (w_r_data !== 32'h11223344) begin errors++; $display("FAIL wd_upper_lane got %h want 11223344", w_r_data); end
        checks++; if (w_r_id !== 2'd2) begin errors++; $display("FAIL wd_id got %0d want 2", w_r_id); end
        tick();
        w_ar_id = 2'd3; w_ar_addr = 16'h0008; w_ar_valid = 1'b1;
        tick();
        w_ar_valid = 1'b0;
        w_n_r_id = 2'd3; w_n_r_data = 64'hCAFEF00D_0BADBEEF; w_n_r_resp = 2'b01; w_n_r_valid = 1'b1;
        tick();
        w_n_r_valid = 1'b0;
        checks++; if (w_r_data !== 32'h0BADBEEF) begin errors++; $display("FAIL wd_lower_lane got %h want 0BADBEEF", w_r_data); end
        checks++; if (w_r_resp !== 2'b01) begin errors++; $display("FAIL wd_resp got %b want 01", w_r_resp); end
        tick();
    endtask

    task automatic test_conflict();
        lite_req(2'd0, 16'h0020);
        ar_id = 2'd0; ar_addr = 16'h0040; ar_valid = 1'b1;
        #1;
        checks++; if ({ar_ready, n_ar_valid} !== 2'b00) begin errors++; $display("FAIL cf_blocked got %b want 00", {ar_ready, n_ar_valid}); end
        n_r_id = 2'd0; n_r_data = 16'h1111; n_r_resp = 2'b00; n_r_last = 1'b0; n_r_valid = 1'b1;
        tick();
        n_r_data = 16'h2222; n_r_last = 1'b1;
        #1;
        checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL cf_blocked_final got %b want 0", ar_ready); end
        tick();
        n_r_valid = 1'b0; n_r_last = 1'b0;
        #1;
        checks++; if ({ar_ready, n_ar_valid} !== 2'b11) begin errors++; $display("FAIL cf_released got %b want 11", {ar_ready, n_ar_valid}); end
        checks++; if (n_ar_addr !== 16'h0040) begin errors++; $display("FAIL cf_addr got %h want 0040", n_ar_addr); end
        checks++; if (r_data !== 32'h22221111) begin errors++; $display("FAIL cf_first_data got %h want 22221111", r_data); end
        tick();
        ar_valid = 1'b0;
        beat(2'd0, 16'h3333, 2'b00, 1'b0);
        beat(2'd0, 16'h4444, 2'b00, 1'b1);
        checks++; if ({r_valid, r_data} !== {1'b1, 32'h44443333}) begin
            errors++; $display("FAIL cf_second_data got %b/%h want 1/44443333", r_valid, r_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  got_id [3];
        logic [31:0] got_data [3];
        logic [31:0] exp_data [3];
        int          n_got;
        logic        acc;
        exp_data[0] = 32'h10010001; exp_data[1] = 32'h20020002; exp_data[2] = 32'h30030003;
        n_got = 0;
        r_ready = 1'b0;
        for (int i = 1; i <= 3; i++) lite_req(2'(i), 16'(16'h0100 + 4 * i));
        for (int i = 1; i <= 2; i++) begin
            beat(2'(i), 16'(i), 2'b00, 1'b0);
            beat(2'(i), 16'(16'h1000 * i + i), 2'b00, 1'b1);
        end
        checks++; if ({r_valid, r_data} !== {1'b1, 32'h10010001}) begin
            errors++; $display("FAIL bp_head got %b/%h want 1/10010001", r_valid, r_data); end
        n_r_id = 2'd3; n_r_data = 16'h0003; n_r_resp = 2'b00; n_r_last = 1'b0; n_r_valid = 1'b1;
        #1;
        checks++; if (n_r_ready !== 1'b1) begin errors++; $display("FAIL bp_nonfinal_ready got %b want 1", n_r_ready); end
        tick();
        n_r_data = 16'h3003; n_r_last = 1'b1;
        #1;
        checks++; if (n_r_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got %b want 0", n_r_ready); end
        tick();
        checks++; if (n_r_ready !== 1'b0) begin errors++; $display("FAIL bp_hold2 got %b want 0", n_r_ready); end
        r_ready = 1'b1;
        #1;
        for (int c = 0; c < 12 && n_got < 3; c++) begin
            if (r_valid) begin
                got_id[n_got] = r_id; got_data[n_got] = r_data; n_got++;
            end
            acc = n_r_valid && n_r_ready;
            tick();
            if (acc) begin n_r_valid = 1'b0; n_r_last = 1'b0; end
        end
        checks++; if (n_got !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", n_got); end
        for (int k = 0; k < n_got; k++) begin
            checks++;
            if ({got_id[k], got_data[k]} !== {2'(k + 1), exp_data[k]}) begin
                errors++; $display("FAIL bp_order[%0d] got %0d/%h want %0d/%h", k, got_id[k], got_data[k], k + 1, exp_data[k]);
            end
        end
        checks++; if ({r_valid, n_r_valid} !== 2'b00) begin errors++; $display("FAIL bp_drained got %b want 00", {r_valid, n_r_valid}); end
        n_r_valid = 1'b0;
    endtask

    task automatic test_err_merge();
        lite_req(2'd1, 16'h0200);
        beat(2'd1, 16'h00AA, 2'b00, 1'b0);
        beat(2'd1, 16'h00BB, 2'b10, 1'b1);
        checks++; if ({r_resp, r_data} !== {2'b10, 32'h00BB00AA}) begin
            errors++; $display("FAIL em_merge got %b/%h want 10/00BB00AA", r_resp, r_data); end
        tick();
        lite_req(2'd2, 16'h0204);
        beat(2'd2, 16'h5A5A, 2'b00, 1'b1);
        checks++; if ({r_valid, r_id, r_resp, r_data} !== {1'b1, 2'd2, 2'b10, 32'h00005A5A}) begin
            errors++; $display("FAIL em_early_last got %b/%0d/%b/%h want 1/2/10/00005A5A", r_valid, r_id, r_resp, r_data); end
        tick();
        n_r_id = 2'd2; n_r_data = 16'h7777; n_r_resp = 2'b00; n_r_last = 1'b1; n_r_valid = 1'b1;
        #1;
        checks++; if (n_r_ready !== 1'b1) begin errors++; $display("FAIL em_sink_ready got %b want 1", n_r_ready); end
        tick();
        n_r_valid = 1'b0; n_r_last = 1'b0;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL em_sink_nopush got %b want 0", r_valid); end
        lite_req(2'd3, 16'h0208);
        beat(2'd3, 16'h1234, 2'b00, 1'b0);
        beat(2'd3, 16'h5678, 2'b00, 1'b0);
        checks++; if ({r_resp, r_data} !== {2'b10, 32'h56781234}) begin
            errors++; $display("FAIL em_missing_last got %b/%h want 10/56781234", r_resp, r_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        lite_req(2'd0, 16'h0300);
        beat(2'd0, 16'h9999, 2'b00, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        checks++; if ({r_valid, ar_ready} !== 2'b01) begin errors++; $display("FAIL rm_async got %b want 01", {r_valid, ar_ready}); end
        tick();
        rstn = 1'b1;
        n_r_id = 2'd0; n_r_data = 16'h8888; n_r_resp = 2'b00; n_r_last = 1'b1; n_r_valid = 1'b1;
        #1;
        checks++; if (n_r_ready !== 1'b1) begin errors++; $display("FAIL rm_sink_ready got %b want 1", n_r_ready); end
        tick();
        n_r_valid = 1'b0; n_r_last = 1'b0;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rm_sink_nopush got %b want 0", r_valid); end
    endtask

`ifdef LITE_NASTI_READ_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        lite_req(2'd1, 16'h0400);
        repeat (7) tick();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", r_valid); end
        tick();
        checks++; if ({r_valid, r_id, r_resp, r_data} !== {1'b1, 2'd1, 2'b10, 32'h0}) begin
            errors++; $display("FAIL to_push got %b/%0d/%b/%h want 1/1/10/0", r_valid, r_id, r_resp, r_data); end
        tick();
        n_r_id = 2'd1; n_r_data = 16'h4242; n_r_resp = 2'b00; n_r_last = 1'b0; n_r_valid = 1'b1;
        #1;
        checks++; if (n_r_ready !== 1'b1) begin errors++; $display("FAIL to_late_sink got %b want 1", n_r_ready); end
        tick();
        n_r_valid = 1'b0;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL to_late_nopush got %b want 0", r_valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        test_reset();
        test_narrow_burst();
        test_wide_lane();
        test_conflict();
        test_back_to_back();
        test_err_merge();
        test_reset_mid();
`ifdef LITE_NASTI_READ_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
